// File: rtl/usb_rx_ram_writer_if.sv
// rtl/usb_rx_ram_writer_if.sv - byte stream in and RAM port-2 write bus out of the RX ring writer
//
// Signals:
//   in_data/in_valid/in_eop/in_ready   received byte stream (source -> writer)
//   ram_chipselect/ram_write           RAM port 2 strobes (writer -> RAM)
//   ram_address/ram_byteenable         word address and lane enables (bit0 = bits [7:0])
//   ram_writedata                      packed little-endian word
// Modports: master = byte source / RAM side, slave = the writer.
interface usb_rx_ram_writer_if #(
    parameter int ADDR_W = 11
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_eop;
    logic              in_ready;
    logic              ram_chipselect;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_address;
    logic [3:0]        ram_byteenable;
    logic [31:0]       ram_writedata;

    modport master (
        output in_data, in_valid, in_eop,
        input  in_ready,
        input  ram_chipselect, ram_write, ram_address, ram_byteenable, ram_writedata
    );

    modport slave (
        input  in_data, in_valid, in_eop,
        output in_ready,
        output ram_chipselect, ram_write, ram_address, ram_byteenable, ram_writedata
    );
endinterface

// File: rtl/usb_rx_ram_writer.sv
// rtl/usb_rx_ram_writer.sv - packs USB RX bytes into 32-bit words and writes them into a RAM ring
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   enable            1 = accept bytes; 0 = in_ready low, packer state held
//   bus (slave)       byte stream in, RAM port-2 write bus out
//   cpu_rd_ptr        CPU read pointer with wrap bit
//   wr_ptr            write pointer with wrap bit
//   level             words in ring = wr_ptr - cpu_rd_ptr (modulo 2^(DEPTH_LOG2+1))
//   pkt_done          one-cycle pulse alongside the write of a word ending a packet
//   overflow          sticky drop flag (only with USB_RX_DROP_ON_FULL_EN, otherwise 0)
//   ovf_clear         clears overflow
// Build option: define USB_RX_DROP_ON_FULL_EN to drop words on a full ring instead of stalling.
module usb_rx_ram_writer #(
    parameter int ADDR_W     = 11,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    usb_rx_ram_writer_if.slave    bus,
    input  logic [DEPTH_LOG2:0]   cpu_rd_ptr,
    output logic [DEPTH_LOG2:0]   wr_ptr,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  pkt_done,
    output logic                  overflow,
    input  logic                  ovf_clear
);
    localparam logic [DEPTH_LOG2:0] DEPTH_V = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {W_IDLE, W_WRITE, W_STALL} wstate_t;

    wstate_t             state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [31:0]         lanes_q, lanes_d;
    logic [31:0]         out_data_q, out_data_d;
    logic [3:0]          out_be_q, out_be_d;
    logic                out_eop_q, out_eop_d;
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;

    logic                is_write;
    logic [DEPTH_LOG2:0] level_after;
    logic                room;
    logic                word_end;
    logic                in_ready_c;
    logic                accept;
    logic                handover;
    logic [31:0]         merged;
    logic [3:0]          mask;

    assign is_write    = (state_q == W_WRITE);
    assign level       = wr_ptr_q - cpu_rd_ptr;
    // Occupancy once the write in flight this cycle has landed; decides where the next word goes.
    assign level_after = level + {{DEPTH_LOG2{1'b0}}, is_write};
    assign room        = (level_after < DEPTH_V);
    assign word_end    = (cnt_q == 2'd3) | bus.in_eop;

`ifdef USB_RX_DROP_ON_FULL_EN
    assign in_ready_c = enable & reset_n;
`else
    // Only the byte that would complete a word needs the output register; it is
    // blocked solely while a stalled word still sits there.
    assign in_ready_c = enable & reset_n & ~(word_end & (state_q == W_STALL));
`endif

    assign accept   = bus.in_valid & in_ready_c;
    assign handover = accept & word_end;

    // Incoming byte merged into its lane; lanes above cnt are still zero.
    always_comb begin
        merged = lanes_q;
        mask   = 4'b0001;
        case (cnt_q)
            2'd0: begin merged[7:0]   = bus.in_data; mask = 4'b0001; end
            2'd1: begin merged[15:8]  = bus.in_data; mask = 4'b0011; end
            2'd2: begin merged[23:16] = bus.in_data; mask = 4'b0111; end
            default: begin merged[31:24] = bus.in_data; mask = 4'b1111; end
        endcase
    end

`ifdef USB_RX_DROP_ON_FULL_EN
    logic ovf_set;
    logic ovf_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lanes_d    = lanes_q;
        out_data_d = out_data_q;
        out_be_d   = out_be_q;
        out_eop_d  = out_eop_q;
        wr_ptr_d   = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, is_write};
`ifdef USB_RX_DROP_ON_FULL_EN
        ovf_set    = 1'b0;
`endif
        if (accept) begin
            if (word_end) begin
                lanes_d = '0;
                cnt_d   = 2'd0;
            end else begin
                lanes_d = merged;
                cnt_d   = cnt_q + 2'd1;
            end
        end
        case (state_q)
            W_IDLE, W_WRITE: begin
                state_d = W_IDLE;
                if (handover) begin
                    if (room) begin
                        out_data_d = merged;
                        out_be_d   = mask;
                        out_eop_d  = bus.in_eop;
                        state_d    = W_WRITE;
                    end else begin
`ifdef USB_RX_DROP_ON_FULL_EN
                        ovf_set    = 1'b1;
`else
                        out_data_d = merged;
                        out_be_d   = mask;
                        out_eop_d  = bus.in_eop;
                        state_d    = W_STALL;
`endif
                    end
                end
            end
            W_STALL: begin
                if (room) begin
                    state_d = W_WRITE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= W_IDLE;
            cnt_q      <= 2'd0;
            lanes_q    <= '0;
            out_data_q <= '0;
            out_be_q   <= '0;
            out_eop_q  <= 1'b0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lanes_q    <= lanes_d;
            out_data_q <= out_data_d;
            out_be_q   <= out_be_d;
            out_eop_q  <= out_eop_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

`ifdef USB_RX_DROP_ON_FULL_EN
    // Set wins over a same-cycle clear so a drop is never lost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end else if (ovf_clear) begin
            ovf_q <= 1'b0;
        end
    end
    assign overflow = ovf_q;
`else
    logic unused_ovf_clear;
    assign unused_ovf_clear = ovf_clear;
    assign overflow         = 1'b0;
`endif

    assign bus.in_ready       = in_ready_c;
    assign bus.ram_chipselect = is_write;
    assign bus.ram_write      = is_write;
    assign bus.ram_address    = is_write ? ADDR_W'(wr_ptr_q[DEPTH_LOG2-1:0]) : '0;
    assign bus.ram_writedata  = is_write ? out_data_q : '0;
    assign bus.ram_byteenable = is_write ? out_be_q : '0;
    assign pkt_done           = is_write & out_eop_q;
    assign wr_ptr             = wr_ptr_q;
endmodule
